// File: rtl/rk_scan_driver_pkg.sv
// Shared definitions for the MU500-RK two-group 7-segment scan driver.
package rk_scan_driver_pkg;

  localparam int NDIGIT = 4;
  localparam int IW     = $clog2(NDIGIT);

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } seg_pair_t;

  function automatic logic [NDIGIT-1:0] one_hot_sel(input logic [IW-1:0] idx);
    return 4'b1000 >> idx;
  endfunction

endpackage

// File: rtl/rk_scan_driver_scan_timer.sv
// Slot timer: counts DIV cycles per digit slot and steps through the 4 slots.
module rk_scan_driver_scan_timer
  import rk_scan_driver_pkg::*;
#(
  parameter int DIV = 50000,
  parameter int CW  = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [CW-1:0] cnt_o,
  output logic [IW-1:0] idx_o,
  output logic          slot_start_o,
  output logic          frame_end_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_last;

  assign slot_last = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_last) begin
      cnt_d = '0;
      idx_d = idx_q + 1'b1;  // two-bit index wraps 3 -> 0 naturally
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign idx_o        = idx_q;
  assign slot_start_o = (cnt_q == '0);
  assign frame_end_o  = slot_last && (idx_q == IW'(NDIGIT - 1));

endmodule

// File: rtl/rk_scan_driver.sv
// Top: per-slot capture of the active digit pair and registered, blanked outputs.
module rk_scan_driver
  import rk_scan_driver_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 500,
  parameter int CW    = 16
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] rk_a,
  input  logic [7:0] rk_b,
  input  logic [7:0] rk_c,
  input  logic [7:0] rk_d,
  input  logic [7:0] rk_e,
  input  logic [7:0] rk_f,
  input  logic [7:0] rk_g,
  input  logic [7:0] rk_h,
  output logic [7:0] seg_x,
  output logic [3:0] sel_x,
  output logic [7:0] seg_y,
  output logic [3:0] sel_y,
  output logic       frame
);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          slot_start;
  logic          frame_end;

  rk_scan_driver_scan_timer #(
    .DIV(DIV),
    .CW (CW)
  ) u_timer (
    .clk_i       (sys_clock),
    .rst_i       (reset),
    .cnt_o       (cnt),
    .idx_o       (idx),
    .slot_start_o(slot_start),
    .frame_end_o (frame_end)
  );

  seg_pair_t lat_q, lat_d, pick;
  logic      lit;

  always_comb begin
    pick = '{x: rk_a, y: rk_e};
    case (idx)
      2'd1:    pick = '{x: rk_b, y: rk_f};
      2'd2:    pick = '{x: rk_c, y: rk_g};
      2'd3:    pick = '{x: rk_d, y: rk_h};
      default: pick = '{x: rk_a, y: rk_e};
    endcase
  end

  // Digit data is frozen for the whole slot so a digit never tears.
  assign lat_d = slot_start ? pick : lat_q;
  assign lit   = enable && (cnt >= CW'(BLANK));

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      lat_q <= '0;
      seg_x <= '0;
      seg_y <= '0;
      sel_x <= '0;
      sel_y <= '0;
      frame <= 1'b0;
    end else begin
      lat_q <= lat_d;
      frame <= frame_end;
      if (lit) begin
        sel_x <= one_hot_sel(idx);
        sel_y <= one_hot_sel(idx);
        seg_x <= lat_q.x;
        seg_y <= lat_q.y;
      end else begin
        sel_x <= '0;
        sel_y <= '0;
        seg_x <= '0;
        seg_y <= '0;
      end
    end
  end

endmodule
